// File: rtl/spi_mem_controller_if.sv
// Request/response and SPI pin bundle between the requesters, the controller and the spiMemory slave.
// req_valid[i] may rise at any time and must stay high until the cycle where req_ready[i] is also high;
// that cycle is the handshake, and payload fields for requester i are sampled only in that cycle.
interface spi_mem_controller_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_id;
    logic [7:0]  resp_rdata;
    logic        busy;
    logic        cs_pin;
    logic        sclk_pin;
    logic        mosi_pin;
    logic        miso_pin;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, miso_pin,
        input  req_ready, resp_valid, resp_id, resp_rdata, busy, cs_pin, sclk_pin, mosi_pin
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, miso_pin,
        output req_ready, resp_valid, resp_id, resp_rdata, busy, cs_pin, sclk_pin, mosi_pin
    );
endinterface

// File: rtl/spi_mem_controller.sv
// Two-port round-robin arbiter and SPI master issuing one 16-bit frame per command to spiMemory.
// Frame (MSB first): addr[6:0], R/W (1 = read), then write data or zeros; read data captured on bits 8-15.
module spi_mem_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    spi_mem_controller_if.slave  bus,
    output logic [2:0]           state_o
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_SHIFT_LO = 3'd2;
    localparam logic [2:0] S_SHIFT_HI = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0] IDLE_LAST  = 8'(CS_IDLE - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] frame_q, frame_d;
    logic        write_q, write_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_id_q;
    logic [7:0]  resp_rdata_q;
    logic        busy_q, busy_d;

    logic        win;
    logic [1:0]  ready;
    logic        hs;
    logic        win_write;
    logic [6:0]  win_addr;
    logic [7:0]  win_wdata;

    // When both request, the one not granted last time wins; a lone requester always wins.
    always_comb begin
        win = bus.req_valid[1];
        if (bus.req_valid == 2'b11) begin
            win = ~last_q;
        end
        ready = 2'b00;
        if (reset_n && (state_q == S_IDLE) && (|bus.req_valid)) begin
            ready = win ? 2'b10 : 2'b01;
        end
        hs        = |(bus.req_valid & ready);
        win_write = win ? bus.req_write[1]     : bus.req_write[0];
        win_addr  = win ? bus.req_addr[13:7]   : bus.req_addr[6:0];
        win_wdata = win ? bus.req_wdata[15:8]  : bus.req_wdata[7:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        write_d = write_q;
        id_d    = id_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    state_d = S_SETUP;
                    cnt_d   = 8'd0;
                    bit_d   = 4'd0;
                    id_d    = win;
                    last_d  = win;
                    write_d = win_write;
                    frame_d = {win_addr, ~win_write, (win_write ? win_wdata : 8'h00)};
                    rdata_d = 8'h00;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_SHIFT_LO;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SHIFT_LO: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = S_SHIFT_HI;
                    cnt_d   = 8'd0;
                    // Data phase is bits 8-15; MISO has had the whole low phase to settle.
                    if (bit_q[3]) begin
                        rdata_d = {rdata_q[6:0], bus.miso_pin};
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SHIFT_HI: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = 8'd0;
                    if (bit_q == 4'd15) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_SHIFT_LO;
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == IDLE_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Pins are registered from the next state so they line up with the state they belong to.
    always_comb begin
        cs_d         = !((state_d == S_SETUP) || (state_d == S_SHIFT_LO) ||
                         (state_d == S_SHIFT_HI) || (state_d == S_HOLD));
        sclk_d       = (state_d == S_SHIFT_HI);
        mosi_d       = 1'b0;
        if ((state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI)) begin
            mosi_d = frame_d[~bit_d];
        end
        resp_valid_d = (state_q == S_HOLD) && (state_d == S_GAP);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            bit_q        <= 4'd0;
            frame_q      <= 16'h0000;
            write_q      <= 1'b0;
            id_q         <= 1'b0;
            last_q       <= 1'b1;
            rdata_q      <= 8'h00;
            cs_q         <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_rdata_q <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            frame_q      <= frame_d;
            write_q      <= write_d;
            id_q         <= id_d;
            last_q       <= last_d;
            rdata_q      <= rdata_d;
            cs_q         <= cs_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            if (resp_valid_d) begin
                resp_id_q    <= id_q;
                resp_rdata_q <= write_q ? 8'h00 : rdata_q;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.busy       = busy_q;
    assign bus.cs_pin     = cs_q;
    assign bus.sclk_pin   = sclk_q;
    assign bus.mosi_pin   = mosi_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_spi_mem_controller.sv
// Bench for spi_mem_controller: behavioural spiMemory slave, reference memory and response scoreboard.
// A second instance with CLK_DIV=8 is used only for the frame latency measurement.
module tb_spi_mem_controller;
    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int CS_IDLE  = 8;
    localparam int LAT      = 1 + CS_SETUP + 32 * CLK_DIV + CS_HOLD;
    localparam int LAT8     = 1 + CS_SETUP + 32 * 8 + CS_HOLD;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_mem_controller_if bus();
    spi_mem_controller_if bus8();
    logic [2:0] state;
    logic [2:0] state8;

    spi_mem_controller #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .state_o(state)
    );
    spi_mem_controller #(.CLK_DIV(8), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8), .state_o(state8)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard: {id, rdata} pushed at handshake, popped on resp_valid.
    logic [8:0]  exp_q[$];
    logic [15:0] frame_exp_q[$];
    int          t_q[$];
    int          grant_q[$];
    logic [7:0]  ref_mem[128];
    logic [7:0]  slv_mem[128];

    // Monitor state
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b0;
    int          edges = 0;
    int          idle_cnt = 0;
    bit          in_frame = 0;
    bit          seen_frame = 0;
    logic [15:0] cap = 16'h0;
    logic [15:0] last_frame = 16'h0;
    logic [7:0]  last_rdata = 8'h0;
    logic        last_id = 1'b0;
    bit          undo_v = 0;
    logic [6:0]  undo_a = 7'h0;
    logic [7:0]  undo_d = 8'h0;
    logic [1:0]  mon_hs;
    int          mon_id;
    logic        mon_wr;
    logic [6:0]  mon_a;
    logic [7:0]  mon_d;
    logic [8:0]  mon_e;

    always @(negedge clk) begin
        if (!reset_n) begin
            if (undo_v) begin
                ref_mem[undo_a] = undo_d;
                undo_v = 0;
            end
            exp_q.delete();
            frame_exp_q.delete();
            t_q.delete();
            in_frame   = 0;
            seen_frame = 0;
            idle_cnt   = 0;
            check("resp_in_reset", bus.resp_valid, 0);
        end else begin
            if (bus.req_ready != 2'b00) check("ready_onehot", $countones(bus.req_ready), 1);
            mon_hs = bus.req_valid & bus.req_ready;
            if (mon_hs != 2'b00) begin
                mon_id = mon_hs[1] ? 1 : 0;
                check("hs_not_busy", bus.busy, 0);
                grant_q.push_back(mon_id);
                mon_wr = bus.req_write[mon_id];
                mon_a  = bus.req_addr[7*mon_id +: 7];
                mon_d  = bus.req_wdata[8*mon_id +: 8];
                frame_exp_q.push_back({mon_a, ~mon_wr, (mon_wr ? mon_d : 8'h00)});
                t_q.push_back(cyc);
                if (mon_wr) begin
                    undo_v = 1;
                    undo_a = mon_a;
                    undo_d = ref_mem[mon_a];
                    ref_mem[mon_a] = mon_d;
                    exp_q.push_back({mon_id[0], 8'h00});
                end else begin
                    exp_q.push_back({mon_id[0], ref_mem[mon_a]});
                end
            end
            if (bus.resp_valid) begin
                check("resp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("resp_id", bus.resp_id, mon_e[8]);
                    check("resp_rdata", bus.resp_rdata, mon_e[7:0]);
                    check("latency", cyc - t_q.pop_front(), LAT);
                    last_rdata = bus.resp_rdata;
                    last_id    = bus.resp_id;
                    undo_v     = 0;
                end
            end
            if (!bus.cs_pin && cs_prev) begin
                if (seen_frame) check("cs_idle_min", idle_cnt >= CS_IDLE, 1);
                edges    = 0;
                cap      = 16'h0;
                in_frame = 1;
            end
            if (!bus.cs_pin && bus.sclk_pin && !sclk_prev) begin
                edges++;
                cap = {cap[14:0], bus.mosi_pin};
            end
            if (bus.cs_pin && !cs_prev && in_frame) begin
                check("sclk_edges", edges, 16);
                check("frame_expected", frame_exp_q.size() != 0, 1);
                if (frame_exp_q.size() != 0) check("frame", cap, frame_exp_q.pop_front());
                last_frame = cap;
                seen_frame = 1;
                in_frame   = 0;
                idle_cnt   = 0;
            end
            if (bus.cs_pin) idle_cnt++;
        end
        cs_prev   = bus.cs_pin;
        sclk_prev = bus.sclk_pin;
    end

    // spiMemory model: shifts MOSI on SCLK rise, drives MISO after SCLK fall, commits writes at CS rise.
    int         s_cnt = 0;
    logic [15:0] s_shift = 16'h0;
    logic       s_read = 1'b0;
    logic [7:0] s_rd = 8'h0;
    logic       s_sclk = 1'b0;
    logic       s_cs = 1'b1;

    always @(negedge clk) begin
        if (bus.cs_pin !== 1'b0) begin
            if (!s_cs && s_cnt == 16 && !s_shift[8]) slv_mem[s_shift[15:9]] = s_shift[7:0];
            s_cnt = 0;
            bus.miso_pin = 1'b0;
        end else begin
            if (bus.sclk_pin && !s_sclk) begin
                s_shift = {s_shift[14:0], bus.mosi_pin};
                s_cnt++;
                if (s_cnt == 8) begin
                    s_read = s_shift[0];
                    s_rd   = slv_mem[s_shift[7:1]];
                end
            end else if (!bus.sclk_pin && s_sclk && s_cnt >= 8 && s_cnt < 16 && s_read) begin
                bus.miso_pin = s_rd[15 - s_cnt];
            end
        end
        s_sclk = bus.sclk_pin;
        s_cs   = (bus.cs_pin !== 1'b0);
    end

    // Caller is just after a rising edge; returns just after the handshake edge.
    task automatic send(input int id, input logic wr, input logic [6:0] a, input logic [7:0] d, input bit keep);
        int n;
        bus.req_write[id]        = wr;
        bus.req_addr[7*id +: 7]  = a;
        bus.req_wdata[8*id +: 8] = d;
        bus.req_valid[id]        = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready[id] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("hs_seen", bus.req_ready[id], 1);
        @(posedge clk);
        #1;
        if (!keep) bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || state != 3'd0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int n;
        int t8;
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = 8'h00;
            slv_mem[i] = 8'h00;
        end
        bus.req_valid  = 2'b00;
        bus.req_write  = 2'b00;
        bus.req_addr   = 14'h0;
        bus.req_wdata  = 16'h0;
        bus8.req_valid = 2'b00;
        bus8.req_write = 2'b00;
        bus8.req_addr  = 14'h0;
        bus8.req_wdata = 16'h0;
        bus8.miso_pin  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cs", bus.cs_pin, 1);
        check("rst_sclk", bus.sclk_pin, 0);
        check("rst_mosi", bus.mosi_pin, 0);
        check("rst_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_id", bus.resp_id, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_state", state, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Write 0xB1 to 0x7F, read it back
        send(0, 1'b1, 7'h7F, 8'hB1, 0);
        wait_drain();
        check("frame_feb1", last_frame, 16'hFEB1);
        send(0, 1'b0, 7'h7F, 8'h00, 0);
        wait_drain();
        check("readback_b1", last_rdata, 8'hB1);
        check("readback_id", last_id, 0);

        // Simultaneous requests right after reset
        do_reset();
        grant_q.delete();
        fork
            send(0, 1'b1, 7'h55, 8'h92, 0);
            send(1, 1'b0, 7'h55, 8'h00, 0);
        join
        wait_drain();
        check("grant_cnt", grant_q.size(), 2);
        if (grant_q.size() == 2) begin
            check("grant_first", grant_q[0], 0);
            check("grant_second", grant_q[1], 1);
        end
        check("simul_rdata", last_rdata, 8'h92);
        check("simul_id", last_id, 1);

        // Fairness: requester 0 holds valid while requester 1 issues three reads
        grant_q.delete();
        fork
            begin
                send(0, 1'b0, 7'($urandom_range(0, 127)), 8'h00, 1);
                send(0, 1'b1, 7'h20, 8'($urandom_range(0, 255)), 1);
                send(0, 1'b0, 7'h20, 8'h00, 0);
            end
            begin
                for (int i = 0; i < 3; i++) send(1, 1'b0, 7'($urandom_range(0, 127)), 8'h00, 0);
            end
        join
        wait_drain();
        check("fair_cnt", grant_q.size(), 6);
        for (int i = 0; i < 6 && i < grant_q.size(); i++) check("fair_order", grant_q[i], i % 2);

        // Ten back-to-back transactions on a small address window
        for (int i = 0; i < 10; i++) begin
            send(i % 2, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 0);
        end
        wait_drain();

        // Reset during bit 10 of a write; the write must not land
        send(1, 1'b1, 7'h3C, 8'hA5, 0);
        n = 0;
        while (!(edges == 10 && !bus.sclk_pin) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reached_bit10", edges, 10);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_cs", bus.cs_pin, 1);
        check("abort_sclk", bus.sclk_pin, 0);
        check("abort_mosi", bus.mosi_pin, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_resp_valid", bus.resp_valid, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        grant_q.delete();
        send(1, 1'b0, 7'h3C, 8'h00, 0);
        wait_drain();
        check("post_abort_grant", grant_q.size(), 1);
        check("post_abort_rdata", last_rdata, 8'h00);
        check("post_abort_id", last_id, 1);

        // Latency with CLK_DIV=8
        @(posedge clk);
        #1;
        bus8.req_write = 2'b01;
        bus8.req_addr  = 14'h0011;
        bus8.req_wdata = 16'h005A;
        bus8.req_valid = 2'b01;
        n = 0;
        @(negedge clk);
        while (!bus8.req_ready[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hs8_seen", bus8.req_ready[0], 1);
        t8 = cyc;
        @(posedge clk);
        #1 bus8.req_valid = 2'b00;
        n = 0;
        @(negedge clk);
        while (!bus8.resp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("latency_div8", cyc - t8, LAT8);
        check("resp8_rdata", bus8.resp_rdata, 0);

        repeat (20) @(posedge clk);
        check("final_queue", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end
endmodule
